lock_sequencer: RTL

Central mode controller for the keypad password lock. It decides which consumer owns the keypad, either the password-set path or the verify/compare path. It counts failed attempts, enforces a timed lockout with alarm after too many failures, and holds the unlocked state for a fixed time. It sits between the keypad and the set_password/compare logic, and drives the lights and countdown display.

---
 rtl/lock_sequencer_pkg.sv | 16 +
 rtl/sec_timer.sv | 40 ++++
 rtl/lock_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lock_sequencer_pkg.sv
// Shared definitions for the keypad lock mode controller: state encoding
// and the width of the second-resolution timers.
package lock_sequencer_pkg;

   localparam int TIMER_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SET     = 3'd1,
      ST_VERIFY  = 3'd2,
      ST_CHECK   = 3'd3,
      ST_OPEN    = 3'd4,
      ST_LOCKOUT = 3'd5
   } state_e;

endpackage

// File: rtl/sec_timer.sv
// Loadable down-counter stepped by the timing tick. A load always wins over
// a tick in the same cycle; the count holds at zero instead of wrapping.
module sec_timer
   import lock_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               tick,
   output logic [TIMER_W-1:0] count,
   output logic               zero
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   // Next count: load has priority, otherwise step down on tick until zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - TIMER_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Mode controller for the keypad password lock. Routes the keypad to the
// set or verify path, counts consecutive failed verifies, enforces a timed
// lockout with alarm, and holds the lock open for a fixed time.
module lock_sequencer
   import lock_sequencer_pkg::*;
#(
   parameter int unsigned MAX_FAILS     = 3,
   parameter int unsigned LOCK_SECS     = 9,
   parameter int unsigned UNLOCK_SECS   = 5,
   parameter int unsigned ENTRY_TIMEOUT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       key_valid,
   input  logic       set_btn,
   input  logic       verify_btn,
   input  logic       cmp_true,
   input  logic       cmp_false,
   input  logic       set_done,
   output logic       set_en,
   output logic       verify_en,
   output logic       clear_entry,
   output logic       unlocked,
   output logic       alarm,
   output logic [2:0] fail_cnt,
   output logic [3:0] cnt_down,
   output logic [2:0] state_o
);

   state_e state_q, state_d;
   logic [2:0] fail_cnt_q, fail_cnt_d;
   logic       result_q, result_d;
   logic       clear_q, clear_d;
   logic       set_en_q, set_en_d;
   logic       verify_en_q, verify_en_d;
   logic       unlocked_q, unlocked_d;
   logic       alarm_q, alarm_d;

   // Inactivity timer (SET/VERIFY) and hold timer (OPEN/LOCKOUT).
   logic               entry_active, entry_load, entry_tick, entry_zero, entry_expire;
   logic [TIMER_W-1:0] entry_cnt;
   logic               hold_active, hold_load, hold_tick, hold_zero, hold_expire;
   logic [TIMER_W-1:0] hold_cnt, hold_val;

   assign entry_active = (state_q == ST_SET) || (state_q == ST_VERIFY);
   assign hold_active  = (state_q == ST_OPEN) || (state_q == ST_LOCKOUT);

   // Entry timer reloads when an entry starts and on every key press.
   assign entry_load   = ((state_q == ST_IDLE) && (state_d != ST_IDLE)) ||
                         (entry_active && key_valid);
   assign entry_tick   = tick && entry_active;
   // The tick that takes the count from 1 to 0 ends the entry, unless a key
   // press in the same cycle reloads it.
   assign entry_expire = entry_tick && !key_valid && (entry_cnt == TIMER_W'(1));

   // Hold timer is loaded when CHECK hands over to OPEN or LOCKOUT.
   assign hold_load    = (state_q == ST_CHECK) && (state_d != ST_IDLE);
   assign hold_val     = (state_d == ST_OPEN) ? TIMER_W'(UNLOCK_SECS) : TIMER_W'(LOCK_SECS);
   assign hold_tick    = tick && hold_active;
   assign hold_expire  = hold_tick && (hold_cnt == TIMER_W'(1));

   sec_timer u_entry_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (entry_load),
      .load_val (TIMER_W'(ENTRY_TIMEOUT)),
      .tick     (entry_tick),
      .count    (entry_cnt),
      .zero     (entry_zero)
   );

   sec_timer u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load),
      .load_val (hold_val),
      .tick     (hold_tick),
      .count    (hold_cnt),
      .zero     (hold_zero)
   );

   // Next-state, failure bookkeeping and next values of the registered outputs.
   // A zero timer in an active state is treated as expired so the FSM can
   // never stall there.
   always_comb begin
      state_d    = state_q;
      fail_cnt_d = fail_cnt_q;
      result_d   = result_q;
      clear_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (verify_btn) begin
               state_d = ST_VERIFY;
               clear_d = 1'b1;
            end else if (set_btn) begin
               state_d = ST_SET;
               clear_d = 1'b1;
            end
         end
         ST_SET: begin
            if (set_done) begin
               state_d    = ST_IDLE;
               fail_cnt_d = '0;
            end else if (entry_expire || entry_zero) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end
         end
         ST_VERIFY: begin
            if (cmp_true || cmp_false) begin
               state_d  = ST_CHECK;
               // Both pulses together is illegal; fail safe.
               result_d = cmp_true && !cmp_false;
            end else if (entry_expire || entry_zero) begin
               state_d = ST_IDLE;
               clear_d = 1'b1;
            end
         end
         ST_CHECK: begin
            clear_d = 1'b1;
            if (result_q) begin
               state_d    = ST_OPEN;
               fail_cnt_d = '0;
            end else begin
               fail_cnt_d = (fail_cnt_q >= 3'(MAX_FAILS)) ? 3'(MAX_FAILS)
                                                          : fail_cnt_q + 3'd1;
               state_d    = (fail_cnt_d == 3'(MAX_FAILS)) ? ST_LOCKOUT : ST_IDLE;
            end
         end
         ST_OPEN: begin
            if (hold_expire || hold_zero) begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (hold_expire || hold_zero) begin
               state_d    = ST_IDLE;
               fail_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            fail_cnt_d = '0;
         end
      endcase
      set_en_d    = (state_d == ST_SET);
      verify_en_d = (state_d == ST_VERIFY);
      unlocked_d  = (state_d == ST_OPEN);
      alarm_d     = (state_d == ST_LOCKOUT);
   end

   // State, failure count, latched compare result and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         fail_cnt_q  <= '0;
         result_q    <= 1'b0;
         clear_q     <= 1'b0;
         set_en_q    <= 1'b0;
         verify_en_q <= 1'b0;
         unlocked_q  <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         fail_cnt_q  <= fail_cnt_d;
         result_q    <= result_d;
         clear_q     <= clear_d;
         set_en_q    <= set_en_d;
         verify_en_q <= verify_en_d;
         unlocked_q  <= unlocked_d;
         alarm_q     <= alarm_d;
      end
   end

   // Countdown display shows whichever timer belongs to the current state.
   always_comb begin
      cnt_down = '0;
      case (state_q)
         ST_SET, ST_VERIFY:  cnt_down = entry_cnt;
         ST_OPEN, ST_LOCKOUT: cnt_down = hold_cnt;
         default:            cnt_down = '0;
      endcase
   end

   assign set_en      = set_en_q;
   assign verify_en   = verify_en_q;
   assign clear_entry = clear_q;
   assign unlocked    = unlocked_q;
   assign alarm       = alarm_q;
   assign fail_cnt    = fail_cnt_q;
   assign state_o     = state_q;

endmodule
